// File: rtl/flight_loop_sequencer.sv
// Periodic flight-loop scheduler: fires angle -> rate -> mixer once per period with
// start/complete handshakes, per-stage watchdog, overrun counting and a sticky fault report.
module flight_loop_sequencer #(
    parameter int LOOP_PERIOD_US = 2000,
    parameter int STAGE_TIMEOUT  = 64
) (
    input  logic        us_clk,
    input  logic        resetn,
    input  logic        enable,
    input  logic        angle_complete,
    input  logic        rate_complete,
    input  logic        mixer_complete,
    output logic        angle_start,
    output logic        rate_start,
    output logic        mixer_start,
    output logic        loop_busy,
    output logic        loop_done,
    output logic [15:0] loop_count,
    output logic [7:0]  overrun_count,
    output logic        timeout_fault,
    output logic [1:0]  fault_stage
);

    typedef enum logic [3:0] {
        IDLE, A_START, A_WAIT, R_START, R_WAIT, M_START, M_WAIT, DONE, FAULT
    } state_e;

    localparam logic [15:0] PERIOD_LAST = 16'(LOOP_PERIOD_US - 1);
    localparam logic [7:0]  WD_LIMIT    = 8'(STAGE_TIMEOUT);

    state_e      state_q, state_d;
    logic [15:0] period_q, period_d;
    logic [7:0]  wd_q, wd_d, wd_inc;
    logic [15:0] loop_count_q, loop_count_d;
    logic [7:0]  overrun_count_q, overrun_count_d;
    logic        timeout_fault_q, timeout_fault_d;
    logic [1:0]  fault_stage_q, fault_stage_d;
    logic        angle_start_q, angle_start_d;
    logic        rate_start_q, rate_start_d;
    logic        mixer_start_q, mixer_start_d;
    logic        loop_busy_q, loop_busy_d;
    logic        loop_done_q, loop_done_d;
    logic        run, tick, in_pass;

    // The period counter only free-runs while armed and healthy, so a fault or
    // a disarm always restarts the full period on the next enable.
    always_comb begin
        run      = enable && (state_q != FAULT);
        tick     = run && (period_q == PERIOD_LAST);
        period_d = (run && !tick) ? period_q + 16'd1 : 16'd0;
    end

    always_comb begin
        state_d         = state_q;
        wd_d            = '0;
        wd_inc          = wd_q + 8'd1;
        loop_count_d    = loop_count_q;
        overrun_count_d = overrun_count_q;
        timeout_fault_d = timeout_fault_q;
        fault_stage_d   = fault_stage_q;
        in_pass         = state_q inside {A_START, A_WAIT, R_START, R_WAIT, M_START, M_WAIT};

        if (state_q == FAULT) begin
            if (!enable) begin
                state_d         = IDLE;
                timeout_fault_d = 1'b0;
                fault_stage_d   = 2'd0;
            end
        end else if (!enable) begin
            state_d = IDLE;
        end else begin
            if (tick && in_pass && (overrun_count_q != 8'hFF))
                overrun_count_d = overrun_count_q + 8'd1;

            // Completion is checked before the watchdog so a response on the
            // last allowed cycle still counts as success.
            case (state_q)
                IDLE:    if (tick) state_d = A_START;
                A_START: state_d = A_WAIT;
                A_WAIT: begin
                    wd_d = wd_inc;
                    if (angle_complete) begin
                        state_d = R_START;
                    end else if (wd_inc == WD_LIMIT) begin
                        state_d         = FAULT;
                        timeout_fault_d = 1'b1;
                        fault_stage_d   = 2'd1;
                    end
                end
                R_START: state_d = R_WAIT;
                R_WAIT: begin
                    wd_d = wd_inc;
                    if (rate_complete) begin
                        state_d = M_START;
                    end else if (wd_inc == WD_LIMIT) begin
                        state_d         = FAULT;
                        timeout_fault_d = 1'b1;
                        fault_stage_d   = 2'd2;
                    end
                end
                M_START: state_d = M_WAIT;
                M_WAIT: begin
                    wd_d = wd_inc;
                    if (mixer_complete) begin
                        state_d      = DONE;
                        loop_count_d = loop_count_q + 16'd1;
                    end else if (wd_inc == WD_LIMIT) begin
                        state_d         = FAULT;
                        timeout_fault_d = 1'b1;
                        fault_stage_d   = 2'd3;
                    end
                end
                DONE:    state_d = tick ? A_START : IDLE;
                default: state_d = IDLE;
            endcase
        end

        angle_start_d = (state_d == A_START);
        rate_start_d  = (state_d == R_START);
        mixer_start_d = (state_d == M_START);
        loop_busy_d   = !(state_d inside {IDLE, FAULT});
        loop_done_d   = (state_d == DONE);
    end

    always_ff @(posedge us_clk or negedge resetn) begin
        if (!resetn) begin
            state_q         <= IDLE;
            period_q        <= '0;
            wd_q            <= '0;
            loop_count_q    <= '0;
            overrun_count_q <= '0;
            timeout_fault_q <= 1'b0;
            fault_stage_q   <= '0;
            angle_start_q   <= 1'b0;
            rate_start_q    <= 1'b0;
            mixer_start_q   <= 1'b0;
            loop_busy_q     <= 1'b0;
            loop_done_q     <= 1'b0;
        end else begin
            state_q         <= state_d;
            period_q        <= period_d;
            wd_q            <= wd_d;
            loop_count_q    <= loop_count_d;
            overrun_count_q <= overrun_count_d;
            timeout_fault_q <= timeout_fault_d;
            fault_stage_q   <= fault_stage_d;
            angle_start_q   <= angle_start_d;
            rate_start_q    <= rate_start_d;
            mixer_start_q   <= mixer_start_d;
            loop_busy_q     <= loop_busy_d;
            loop_done_q     <= loop_done_d;
        end
    end

    assign angle_start   = angle_start_q;
    assign rate_start    = rate_start_q;
    assign mixer_start   = mixer_start_q;
    assign loop_busy     = loop_busy_q;
    assign loop_done     = loop_done_q;
    assign loop_count    = loop_count_q;
    assign overrun_count = overrun_count_q;
    assign timeout_fault = timeout_fault_q;
    assign fault_stage   = fault_stage_q;

endmodule

// File: tb/tb_flight_loop_sequencer.sv
// Scoreboard bench: expected start/done events (kind, cycle) are queued when each
// scenario is armed and matched against the DUT pulses as they appear.
module tb_flight_loop_sequencer;

    localparam int P  = 20;
    localparam int TO = 8;

    logic        us_clk = 1'b0;
    logic        resetn = 1'b0;
    logic        enable = 1'b0;
    logic        angle_complete = 1'b0;
    logic        rate_complete  = 1'b0;
    logic        mixer_complete = 1'b0;
    logic        angle_start, rate_start, mixer_start, loop_busy, loop_done;
    logic [15:0] loop_count;
    logic [7:0]  overrun_count;
    logic        timeout_fault;
    logic [1:0]  fault_stage;

    flight_loop_sequencer #(.LOOP_PERIOD_US(P), .STAGE_TIMEOUT(TO)) dut (
        .us_clk(us_clk), .resetn(resetn), .enable(enable),
        .angle_complete(angle_complete), .rate_complete(rate_complete),
        .mixer_complete(mixer_complete),
        .angle_start(angle_start), .rate_start(rate_start), .mixer_start(mixer_start),
        .loop_busy(loop_busy), .loop_done(loop_done), .loop_count(loop_count),
        .overrun_count(overrun_count), .timeout_fault(timeout_fault),
        .fault_stage(fault_stage)
    );

    always #5 us_clk = ~us_clk;

    int cyc = 0;
    always @(posedge us_clk) cyc <= cyc + 1;

    int errors = 0;
    int checks = 0;
    int exp_loops = 0;
    int exp_ovr = 0;

    typedef struct { int kind; int at; } ev_t;
    ev_t exp_q[$];

    // Stage responder: delay k (cycles after start) per stage; k < 0 means never respond.
    int ka = 4, kr = 4, km = 4;
    int due_a = -1, due_r = -1, due_m = -1;
    always @(negedge us_clk) begin
        if (angle_start && ka >= 0) due_a = cyc + ka;
        if (rate_start  && kr >= 0) due_r = cyc + kr;
        if (mixer_start && km >= 0) due_m = cyc + km;
        angle_complete = (cyc == due_a);
        rate_complete  = (cyc == due_r);
        mixer_complete = (cyc == due_m);
    end

    // Event monitor: kind 0 angle_start, 1 rate_start, 2 mixer_start, 3 loop_done.
    always @(negedge us_clk) begin
        logic [3:0] ev;
        ev_t e;
        ev = {loop_done, mixer_start, rate_start, angle_start};
        for (int k = 0; k < 4; k++) begin
            if (ev[k]) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL event: unexpected kind %0d at cycle %0d, expected no event", k, cyc);
                end else begin
                    e = exp_q.pop_front();
                    if (e.kind !== k || e.at !== cyc) begin
                        errors++;
                        $display("FAIL event: got kind %0d at cycle %0d, expected kind %0d at cycle %0d",
                                 k, cyc, e.kind, e.at);
                    end
                end
            end
        end
    end

    task automatic push_ev(input int kind, input int at);
        ev_t e;
        e.kind = kind;
        e.at   = at;
        exp_q.push_back(e);
    endtask

    // Expected pulses for one full pass whose angle_start lands at cycle a.
    task automatic push_pass(input int a, input int da, input int dr, input int dm);
        push_ev(0, a);
        push_ev(1, a + da + 1);
        push_ev(2, a + da + dr + 2);
        push_ev(3, a + da + dr + dm + 3);
    endtask

    task automatic wait_until(input int t);
        while (cyc < t) @(negedge us_clk);
    endtask

    task automatic arm(output int a);
        @(negedge us_clk);
        a = cyc + P;
        enable = 1'b1;
    endtask

    task automatic drain(input string name);
        repeat (3) @(negedge us_clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL %s_pending: got %0d missing events, expected 0 (next kind %0d at cycle %0d)",
                     name, exp_q.size(), exp_q[0].kind, exp_q[0].at);
        end
        exp_q.delete();
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        enable = 1'b0;
        repeat (3) @(negedge us_clk);
        checks++;
        if ({angle_start, rate_start, mixer_start, loop_busy, loop_done} !== 5'b0) begin
            errors++;
            $display("FAIL reset_pulses: got %b, expected 00000",
                     {angle_start, rate_start, mixer_start, loop_busy, loop_done});
        end
        checks++;
        if ({loop_count, overrun_count, timeout_fault, fault_stage} !== 27'd0) begin
            errors++;
            $display("FAIL reset_counts: got loop %0d ovr %0d fault %0b stage %0d, expected all 0",
                     loop_count, overrun_count, timeout_fault, fault_stage);
        end
        resetn = 1'b1;
        repeat (2) @(negedge us_clk);
    endtask

    task automatic test_nominal();
        int a;
        ka = 4; kr = 4; km = 4;
        arm(a);
        push_pass(a, 4, 4, 4);
        push_pass(a + P, 4, 4, 4);
        push_pass(a + 2 * P, 4, 4, 4);
        wait_until(a - 1);
        checks++;
        if (loop_busy !== 1'b0) begin
            errors++; $display("FAIL nominal_busy_pre: got %0b, expected 0", loop_busy);
        end
        wait_until(a + 3);
        checks++;
        if (loop_busy !== 1'b1) begin
            errors++; $display("FAIL nominal_busy_wait: got %0b, expected 1", loop_busy);
        end
        wait_until(a + 16);
        checks++;
        if (loop_count !== 16'(exp_loops + 1)) begin
            errors++; $display("FAIL nominal_count1: got %0d, expected %0d", loop_count, exp_loops + 1);
        end
        wait_until(a + 56);
        checks++;
        if (loop_count !== 16'(exp_loops + 3) || overrun_count !== 8'(exp_ovr) || loop_busy !== 1'b0) begin
            errors++;
            $display("FAIL nominal_end: got loop %0d ovr %0d busy %0b, expected loop %0d ovr %0d busy 0",
                     loop_count, overrun_count, loop_busy, exp_loops + 3, exp_ovr);
        end
        exp_loops += 3;
        enable = 1'b0;
        drain("nominal");
    endtask

    // Pass latency equals the period exactly, so each tick lands in DONE.
    task automatic test_back_to_back();
        int a;
        ka = 5; kr = 5; km = 6;
        arm(a);
        push_pass(a, 5, 5, 6);
        push_pass(a + P, 5, 5, 6);
        wait_until(a + 39);
        enable = 1'b0;
        wait_until(a + 41);
        checks++;
        if (loop_count !== 16'(exp_loops + 2) || overrun_count !== 8'(exp_ovr)) begin
            errors++;
            $display("FAIL b2b_counts: got loop %0d ovr %0d, expected loop %0d ovr %0d",
                     loop_count, overrun_count, exp_loops + 2, exp_ovr);
        end
        exp_loops += 2;
        drain("b2b");
    endtask

    task automatic test_overrun();
        int a;
        ka = 7; kr = 7; km = 7;
        arm(a);
        push_pass(a, 7, 7, 7);
        wait_until(a + 19);
        checks++;
        if (overrun_count !== 8'(exp_ovr)) begin
            errors++; $display("FAIL overrun_before: got %0d, expected %0d", overrun_count, exp_ovr);
        end
        wait_until(a + 20);
        checks++;
        if (overrun_count !== 8'(exp_ovr + 1)) begin
            errors++; $display("FAIL overrun_after: got %0d, expected %0d", overrun_count, exp_ovr + 1);
        end
        wait_until(a + 25);
        checks++;
        if (loop_count !== 16'(exp_loops + 1)) begin
            errors++; $display("FAIL overrun_loops: got %0d, expected %0d", loop_count, exp_loops + 1);
        end
        exp_ovr++;
        exp_loops++;
        enable = 1'b0;
        drain("overrun");
    endtask

    task automatic test_abort();
        int a, a2;
        ka = 4; kr = 4; km = 4;
        arm(a);
        push_ev(0, a);
        push_ev(1, a + 5);
        wait_until(a + 7);
        checks++;
        if (loop_busy !== 1'b1) begin
            errors++; $display("FAIL abort_busy_wait: got %0b, expected 1", loop_busy);
        end
        enable = 1'b0;
        wait_until(a + 8);
        checks++;
        if (loop_busy !== 1'b0) begin
            errors++; $display("FAIL abort_busy_idle: got %0b, expected 0", loop_busy);
        end
        wait_until(a + 30);
        checks++;
        if (loop_count !== 16'(exp_loops)) begin
            errors++; $display("FAIL abort_loops: got %0d, expected %0d", loop_count, exp_loops);
        end
        drain("abort");
        arm(a2);
        push_pass(a2, 4, 4, 4);
        wait_until(a2 + 16);
        checks++;
        if (loop_count !== 16'(exp_loops + 1)) begin
            errors++; $display("FAIL abort_rearm_loops: got %0d, expected %0d", loop_count, exp_loops + 1);
        end
        exp_loops++;
        enable = 1'b0;
        drain("rearm");
    endtask

    // rate_complete arrives on the last watchdog cycle and must still succeed.
    task automatic test_boundary();
        int a;
        ka = 3; kr = TO; km = 4;
        arm(a);
        push_pass(a, 3, TO, 4);
        wait_until(a + 19);
        checks++;
        if (timeout_fault !== 1'b0 || loop_count !== 16'(exp_loops + 1)) begin
            errors++;
            $display("FAIL boundary: got fault %0b loop %0d, expected fault 0 loop %0d",
                     timeout_fault, loop_count, exp_loops + 1);
        end
        exp_loops++;
        enable = 1'b0;
        drain("boundary");
    endtask

    task automatic test_stale();
        int a;
        ka = 0; kr = 4; km = 4;
        arm(a);
        push_ev(0, a);
        wait_until(a + TO);
        checks++;
        if (timeout_fault !== 1'b0 || loop_busy !== 1'b1) begin
            errors++;
            $display("FAIL stale_pre: got fault %0b busy %0b, expected fault 0 busy 1", timeout_fault, loop_busy);
        end
        wait_until(a + TO + 1);
        checks++;
        if (timeout_fault !== 1'b1 || fault_stage !== 2'd1 || loop_busy !== 1'b0) begin
            errors++;
            $display("FAIL stale_fault: got fault %0b stage %0d busy %0b, expected fault 1 stage 1 busy 0",
                     timeout_fault, fault_stage, loop_busy);
        end
        enable = 1'b0;
        @(negedge us_clk);
        checks++;
        if (timeout_fault !== 1'b0 || fault_stage !== 2'd0) begin
            errors++;
            $display("FAIL stale_clear: got fault %0b stage %0d, expected 0 0", timeout_fault, fault_stage);
        end
        drain("stale");
    endtask

    task automatic test_timeout();
        int a;
        ka = 4; kr = 4; km = -1;
        arm(a);
        push_ev(0, a);
        push_ev(1, a + 5);
        push_ev(2, a + 10);
        wait_until(a + 10 + TO);
        checks++;
        if (timeout_fault !== 1'b0 || loop_busy !== 1'b1) begin
            errors++;
            $display("FAIL timeout_pre: got fault %0b busy %0b, expected fault 0 busy 1", timeout_fault, loop_busy);
        end
        wait_until(a + 11 + TO);
        checks++;
        if (timeout_fault !== 1'b1 || fault_stage !== 2'd3 || loop_busy !== 1'b0) begin
            errors++;
            $display("FAIL timeout_fault: got fault %0b stage %0d busy %0b, expected fault 1 stage 3 busy 0",
                     timeout_fault, fault_stage, loop_busy);
        end
        wait_until(a + 70);
        checks++;
        if (timeout_fault !== 1'b1 || overrun_count !== 8'(exp_ovr) || loop_count !== 16'(exp_loops)) begin
            errors++;
            $display("FAIL timeout_hold: got fault %0b ovr %0d loop %0d, expected fault 1 ovr %0d loop %0d",
                     timeout_fault, overrun_count, loop_count, exp_ovr, exp_loops);
        end
        enable = 1'b0;
        @(negedge us_clk);
        checks++;
        if (timeout_fault !== 1'b0 || fault_stage !== 2'd0) begin
            errors++;
            $display("FAIL timeout_clear: got fault %0b stage %0d, expected 0 0", timeout_fault, fault_stage);
        end
        drain("timeout");
    endtask

    task automatic test_reset_mid_pass();
        int a, r;
        ka = 4; kr = 4; km = 4;
        arm(a);
        wait_until(a - 1);
        @(posedge us_clk);
        #1;
        checks++;
        if (angle_start !== 1'b1) begin
            errors++; $display("FAIL midreset_start_pre: got %0b, expected 1", angle_start);
        end
        resetn = 1'b0;
        #1;
        checks++;
        if (angle_start !== 1'b0 || loop_busy !== 1'b0 || loop_count !== 16'd0 || overrun_count !== 8'd0) begin
            errors++;
            $display("FAIL midreset_zero: got start %0b busy %0b loop %0d ovr %0d, expected all 0",
                     angle_start, loop_busy, loop_count, overrun_count);
        end
        exp_loops = 0;
        exp_ovr   = 0;
        repeat (3) @(negedge us_clk);
        r = cyc;
        resetn = 1'b1;
        push_pass(r + P, 4, 4, 4);
        wait_until(r + P - 1);
        checks++;
        if (loop_busy !== 1'b0) begin
            errors++; $display("FAIL midreset_idle: got %0b, expected 0", loop_busy);
        end
        wait_until(r + P + 16);
        checks++;
        if (loop_count !== 16'd1 || overrun_count !== 8'd0) begin
            errors++;
            $display("FAIL midreset_pass: got loop %0d ovr %0d, expected loop 1 ovr 0", loop_count, overrun_count);
        end
        enable = 1'b0;
        drain("midreset");
    endtask

    initial begin
        test_reset();
        test_nominal();
        test_back_to_back();
        test_overrun();
        test_abort();
        test_boundary();
        test_stale();
        test_timeout();
        test_reset_mid_pass();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1, "time limit");
    end

endmodule

// File: doc/flight_loop_sequencer.md
Name: flight_loop_sequencer

Overview:
Periodic scheduler for the flight-control datapath. Every LOOP_PERIOD_US microseconds it sequences the three control stages in fixed order: angle controller, then rate controller, then motor mixer. It uses start/complete handshakes, a per-stage watchdog, overrun counting and a sticky fault report. It sits between the top level and the control stages and replaces free-running start wiring.

Parameters:
LOOP_PERIOD_US, 2000, control loop period in us_clk cycles (500 Hz at 1 MHz); legal range 16..65535.
STAGE_TIMEOUT, 64, max cycles a stage may take in its WAIT state before a fault; legal range 2..255.

Ports:
us_clk  in  1  1 MHz system clock; all logic on rising edge.
resetn  in  1  asynchronous, active-low reset.
enable  in  1  run request (armed); low aborts and holds the block idle.
angle_complete  in  1  completion pulse from the angle controller.
rate_complete  in  1  completion pulse from the rate controller.
mixer_complete  in  1  completion pulse from the motor mixer.
angle_start  out  1  one-cycle start pulse to the angle controller.
rate_start  out  1  one-cycle start pulse to the rate controller.
mixer_start  out  1  one-cycle start pulse to the motor mixer.
loop_busy  out  1  high while a loop pass is in progress.
loop_done  out  1  one-cycle pulse when all three stages complete.
loop_count  out  16  completed passes; wraps from 0xFFFF to 0.
overrun_count  out  8  ticks dropped because the previous pass was still busy; saturates at 255.
timeout_fault  out  1  sticky stage-timeout flag.
fault_stage  out  2  stage that timed out: 0 none, 1 angle, 2 rate, 3 mixer.

Behaviour:
- Reset: all outputs 0, state IDLE, period and watchdog counters 0.
- Period counter:
  - Counts 0..LOOP_PERIOD_US-1 while enable is high and the state is not FAULT; held at 0 otherwise.
  - Internal tick = counter at LOOP_PERIOD_US-1 (wrap cycle).
  - First tick occurs LOOP_PERIOD_US cycles after enable rises.
- States: IDLE, A_START, A_WAIT, R_START, R_WAIT, M_START, M_WAIT, DONE, FAULT. All outputs are registered.
- Start pulses:
  - angle_start, rate_start and mixer_start are high exactly for the one cycle the state is A_START, R_START or M_START respectively.
  - Every START state moves unconditionally to its WAIT state on the next cycle.
- Stage completion:
  - A completion input asserted during its START cycle is stale and ignored.
  - In a WAIT state, the matching completion moves A_WAIT to R_START, R_WAIT to M_START, and M_WAIT to DONE.
  - Completion inputs belonging to other stages are ignored.
- Pass latency: with each stage completing k cycles after its start, tick to loop_done is 3(k+1)+1 cycles.
- Transitions out of IDLE and DONE:
  - IDLE goes to A_START on tick.
  - DONE pulses loop_done, increments loop_count, and goes to IDLE.
  - A tick landing in DONE goes directly to A_START and is not an overrun.
- loop_busy: high in A_START through DONE; low in IDLE and FAULT.
- Overrun: a tick while the state is A_START through M_WAIT is dropped; overrun_count increments, saturating at 255. The running pass continues.
- Watchdog:
  - Cleared on entry to each WAIT state; increments each cycle spent in WAIT.
  - If it reaches STAGE_TIMEOUT with no completion, go to FAULT, set timeout_fault, and set fault_stage to 1, 2 or 3.
  - Completion in the same cycle the watchdog reaches STAGE_TIMEOUT counts as success; completion wins.
- FAULT:
  - No start pulses are issued; ticks are suppressed and are not counted as overruns.
  - Exits to IDLE only when enable is low. Exit clears timeout_fault and fault_stage.
- enable low in any non-FAULT state:
  - Next state is IDLE, and the period counter is zeroed.
  - No loop_done is issued and loop_count is unchanged.
  - Completion pulses arriving after the abort are ignored.
- loop_count and overrun_count clear only on resetn; they are not cleared by enable.
- Asynchronous reset mid-pass: every output drops to 0 immediately, including a start pulse in flight.

Test Plan:
- Nominal pass (LOOP_PERIOD_US=20, STAGE_TIMEOUT=8, each complete returned 4 cycles after its start), enable high → ticks at cycles 19, 39, …; a single angle_start, rate_start and mixer_start each pass; loop_done 16 cycles after each tick; loop_count reaches 3 after 3 periods; overrun_count stays 0.
- Overrun (period 20, rate_complete held off until 30 cycles after rate_start, STAGE_TIMEOUT=40) → the second tick is dropped and overrun_count=1; no second angle_start until the pass finishes; loop_count=1.
- Timeout (STAGE_TIMEOUT=8, mixer_complete never asserted) → 8 cycles after entering M_WAIT: timeout_fault=1, fault_stage=3, loop_busy=0. No further starts despite ticks; enable low → flags clear.
- Boundary completion (rate_complete exactly when the watchdog reaches 8) → no fault; mixer_start follows next cycle. Stale check: angle_complete asserted during the A_START cycle alone → no advance; later timeout with fault_stage=1.
- Abort (enable dropped during R_WAIT, rate_complete pulsed 2 cycles later) → IDLE; no mixer_start, no loop_done; loop_count unchanged. Re-enable → first angle_start 20 cycles later.
- Reset mid-pass (resetn low during A_START) → angle_start, loop_count and overrun_count all 0 immediately; no pulses until 20 cycles after resetn releases with enable high.
